// File: rtl/fifo_pkg.sv
// fifo_pkg: default sizing constants for the synchronous FIFO
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int addr_width(input int depth);
    return $clog2(depth);
  endfunction
  localparam int DEF_ADDR_WIDTH = addr_width(DEF_DEPTH);
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: register array with one synchronous write port and a registered read port
module fifo_mem import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the read register is reset; storage contents are don't-care after reset
  always_ff @(posedge clk)
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers, full/empty flags and registered read data
module sync_fifo import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR_WIDTH = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  full,
  output logic                  empty,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[ADDR_WIDTH], rd_ptr[ADDR_WIDTH-1:0]};
  assign wr_ok = rst & write_en & ~full;
  assign rd_ok = rst & read_en & ~empty;
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .rst(rst),
    .we(wr_ok),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .re(rd_ok),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(data_out)
  );
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo
module tb_sync_fifo;
  logic clk = 0;
  logic rst = 0;
  logic write_en = 0;
  logic read_en = 0;
  logic [7:0] data_in = 0;
  logic full, empty;
  logic [7:0] data_out;
  int checks = 0;
  int errors = 0;
  logic [7:0] vals [16] = '{8'h01, 8'h3c, 8'h7e, 8'h99, 8'hff, 8'h00, 8'h55, 8'haa,
                            8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde, 8'hf0};

  sync_fifo dut (
    .clk(clk),
    .rst(rst),
    .write_en(write_en),
    .read_en(read_en),
    .data_in(data_in),
    .full(full),
    .empty(empty),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0;
    write_en = 1;
    data_in = 8'h01;
    step();
    step();
    write_en = 0;
    rst = 1;
    step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data_out); end
  endtask

  task automatic test_fill();
    write_en = 1;
    for (int i = 0; i < 16; i++) begin
      data_in = vals[i];
      step();
      checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); end
      checks++; if (full !== (i == 15)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, i == 15); end
    end
  endtask

  task automatic test_overflow();
    data_in = 8'hee;
    step();
    step();
    write_en = 0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b exp 1", full); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL overflow_empty got %b exp 0", empty); end
  endtask

  task automatic test_drain();
    read_en = 1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (data_out !== vals[i]) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_out, vals[i]); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got %b exp 0", i, full); end
      checks++; if (empty !== (i == 15)) begin errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, empty, i == 15); end
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (data_out !== 8'hf0) begin errors++; $display("FAIL underflow_data[%0d] got %h exp f0", i, data_out); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL underflow_empty[%0d] got %b exp 1", i, empty); end
    end
    read_en = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    write_en = 1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'ha0 + 8'(i);
      step();
    end
    read_en = 1;
    for (int i = 0; i < 20; i++) begin
      data_in = 8'hb0 + 8'(i);
      step();
      exp = i < 4 ? 8'ha0 + 8'(i) : 8'hb0 + 8'(i - 4);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, data_out, exp); end
      checks++; if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL b2b_flags[%0d] got e=%b f=%b exp e=0 f=0", i, empty, full); end
    end
    write_en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      exp = 8'hc0 + 8'(i);
      checks++; if (data_out !== exp) begin errors++; $display("FAIL b2b_tail[%0d] got %h exp %h", i, data_out, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_drained got %b exp 1", empty); end
  endtask

  task automatic test_empty_rw();
    write_en = 1;
    read_en = 1;
    data_in = 8'h5a;
    step();
    write_en = 0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL empty_rw_empty got %b exp 0", empty); end
    checks++; if (data_out !== 8'hc3) begin errors++; $display("FAIL empty_rw_data got %h exp c3", data_out); end
    step();
    read_en = 0;
    checks++; if (data_out !== 8'h5a) begin errors++; $display("FAIL empty_rw_pop got %h exp 5a", data_out); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL empty_rw_after got %b exp 1", empty); end
  endtask

  task automatic test_mid_reset();
    write_en = 1;
    data_in = 8'h11;
    step();
    data_in = 8'h22;
    step();
    write_en = 0;
    read_en = 1;
    step();
    read_en = 0;
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL mid_pop got %h exp 11", data_out); end
    rst = 0;
    step();
    rst = 1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_reset_empty got %b exp 1", empty); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL mid_reset_data got %h exp 00", data_out); end
    read_en = 1;
    step();
    read_en = 0;
    checks++; if (data_out !== 8'h00 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset_discard got d=%h e=%b exp d=00 e=1", data_out, empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_back_to_back();
    test_empty_rw();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
